// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS core (lw/sw/add/sub/and/or/slt/beq/addi/j) sharing one ALU and
// one unified memory port with a req/ready handshake.
module mips_multicycle_core #(
  parameter logic [31:0] RESET_PC        = 32'h0,
  parameter int          MEM_ADDR_W      = 10,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ready,
  output logic [31:0]           pc,
  output logic [31:0]           Instr,
  output logic [3:0]            state,
  output logic                  rf_we,
  output logic [4:0]            rf_wa,
  output logic [31:0]           rf_wd,
  output logic                  instr_done,
  output logic                  halted
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11,
    S_HALT   = 4'd15
  } state_t;

  localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] OP_BEQ = 6'h04, OP_ADDI = 6'h08, OP_J = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24;
  localparam logic [5:0] FN_OR = 6'h25, FN_SLT = 6'h2A;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d;
  logic [31:0] a_q, a_d, b_q, b_d, alu_q, alu_d, mdr_q, mdr_d;
  logic        halted_q, halted_d;
  logic [31:0] gpr_q [32];

  logic [5:0]  op, fn;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_sx, rs_val, rt_val, alu_res;
  logic        rtype_ok;
  state_t      illegal_next;

  logic                  req_c, we_c, rfwe_c, done_c;
  logic [MEM_ADDR_W-1:0] addr_c;
  logic [4:0]            rfwa_c;
  logic [31:0]           rfwd_c;

  assign op     = instr_q[31:26];
  assign rs     = instr_q[25:21];
  assign rt     = instr_q[20:16];
  assign rd     = instr_q[15:11];
  assign fn     = instr_q[5:0];
  assign imm_sx = {{16{instr_q[15]}}, instr_q[15:0]};
  assign rs_val = (rs == 5'd0) ? 32'd0 : gpr_q[rs];
  assign rt_val = (rt == 5'd0) ? 32'd0 : gpr_q[rt];
  assign rtype_ok = (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
                    (fn == FN_OR)  || (fn == FN_SLT);
  assign illegal_next = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;

  always_comb begin
    alu_res = 32'd0;
    case (fn)
      FN_ADD:  alu_res = a_q + b_q;
      FN_SUB:  alu_res = a_q - b_q;
      FN_AND:  alu_res = a_q & b_q;
      FN_OR:   alu_res = a_q | b_q;
      FN_SLT:  alu_res = ($signed(a_q) < $signed(b_q)) ? 32'd1 : 32'd0;
      default: alu_res = 32'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    a_d     = a_q;
    b_d     = b_q;
    alu_d   = alu_q;
    mdr_d   = mdr_q;
    req_c   = 1'b0;
    we_c    = 1'b0;
    addr_c  = alu_q[MEM_ADDR_W+1:2];
    rfwe_c  = 1'b0;
    rfwa_c  = rt;
    rfwd_c  = alu_q;
    done_c  = 1'b0;
    case (state_q)
      S_FETCH: begin
        req_c  = 1'b1;
        addr_c = pc_q[MEM_ADDR_W+1:2];
        if (mem_ready) begin
          instr_d = mem_rdata;
          pc_d    = pc_q + 32'd4;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d   = rs_val;
        b_d   = rt_val;
        // Branch target computed speculatively while the opcode is dispatched.
        alu_d = pc_q + {imm_sx[29:0], 2'b00};
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = rtype_ok ? S_EXEC : illegal_next;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = illegal_next;
        endcase
      end
      S_MEMADR: begin
        alu_d   = a_q + imm_sx;
        state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        req_c = 1'b1;
        if (mem_ready) begin
          mdr_d   = mem_rdata;
          state_d = S_MEMWB;
        end
      end
      S_MEMWB: begin
        rfwe_c  = 1'b1;
        rfwd_c  = mdr_q;
        done_c  = 1'b1;
        state_d = S_FETCH;
      end
      S_MEMWR: begin
        req_c = 1'b1;
        we_c  = 1'b1;
        if (mem_ready) begin
          done_c  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        alu_d   = alu_res;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        rfwe_c  = 1'b1;
        rfwa_c  = rd;
        done_c  = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        if (a_q == b_q) pc_d = alu_q;
        done_c  = 1'b1;
        state_d = S_FETCH;
      end
      S_ADDIEX: begin
        alu_d   = a_q + imm_sx;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        rfwe_c  = 1'b1;
        done_c  = 1'b1;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        pc_d    = {pc_q[31:28], instr_q[25:0], 2'b00};
        done_c  = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
    halted_d = (state_d == S_HALT);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      instr_q  <= 32'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      alu_q    <= 32'd0;
      mdr_q    <= 32'd0;
      halted_q <= 1'b0;
      for (int i = 0; i < 32; i++) gpr_q[i] <= 32'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      a_q      <= a_d;
      b_q      <= b_d;
      alu_q    <= alu_d;
      mdr_q    <= mdr_d;
      halted_q <= halted_d;
      // $0 stays hard-wired to zero even though the strobe still pulses.
      if (rfwe_c && (rfwa_c != 5'd0)) gpr_q[rfwa_c] <= rfwd_c;
    end
  end

  assign mem_req    = req_c & reset;
  assign mem_we     = we_c & reset;
  assign mem_addr   = addr_c;
  assign mem_wdata  = b_q;
  assign pc         = pc_q;
  assign Instr      = instr_q;
  assign state      = state_q;
  assign rf_we      = rfwe_c & reset;
  assign rf_wa      = rfwa_c;
  assign rf_wd      = rfwd_c;
  assign instr_done = done_c & reset;
  assign halted     = halted_q;

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Bench for mips_multicycle_core: directed scenarios plus random programs checked
// against an instruction-level reference model.
module tb_mips_multicycle_core;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req, mem_we, mem_ready;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata, pc, instr, rf_wd;
  logic [3:0]  state;
  logic        rf_we, instr_done, halted;
  logic [4:0]  rf_wa;

  always #5 clk = ~clk;

  mips_multicycle_core dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .pc(pc), .Instr(instr), .state(state),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .instr_done(instr_done),
    .halted(halted)
  );

  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic [31:0] ref_gpr [0:31];
  logic [31:0] ref_pc;
  int n_assert = 0;
  int n_fail = 0;
  int stall_left = 0;
  bit rand_ready = 1'b0;

  assign mem_rdata = mem[mem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic load(input int idx, input logic [31:0] w);
    mem[idx] = w;
    ref_mem[idx] = w;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) load(i, 32'd0);
  endtask

  task automatic model_reset();
    ref_pc = 32'd0;
    for (int i = 0; i < 32; i++) ref_gpr[i] = 32'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("rst.mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst.rf_we", {31'd0, rf_we}, 32'd0);
    chk("rst.done", {31'd0, instr_done}, 32'd0);
    chk("rst.state", {28'd0, state}, 32'd0);
    chk("rst.pc", pc, 32'd0);
    chk("rst.instr", instr, 32'd0);
    chk("rst.halted", {31'd0, halted}, 32'd0);
    reset = 1'b1;
    model_reset();
  endtask

  // Architectural reference: executes one instruction from the spec's rules.
  task automatic ref_step(output bit e_rf, output logic [4:0] e_wa, output logic [31:0] e_wd,
                          output bit e_st, output logic [9:0] e_sa, output logic [31:0] e_sd,
                          output int e_lat, output bit e_halt);
    logic [31:0] ins, a, b, sx, npc, ea;
    ins = ref_mem[ref_pc[11:2]];
    a   = ref_gpr[ins[25:21]];
    b   = ref_gpr[ins[20:16]];
    sx  = {{16{ins[15]}}, ins[15:0]};
    ea  = a + sx;
    npc = ref_pc + 32'd4;
    e_rf = 0; e_wa = 0; e_wd = 0; e_st = 0; e_sa = 0; e_sd = 0; e_lat = 0; e_halt = 0;
    case (ins[31:26])
      6'h00: begin
        e_rf = 1; e_wa = ins[15:11]; e_lat = 4;
        case (ins[5:0])
          6'h20: e_wd = a + b;
          6'h22: e_wd = a - b;
          6'h24: e_wd = a & b;
          6'h25: e_wd = a | b;
          6'h2A: e_wd = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: begin e_halt = 1; e_rf = 0; end
        endcase
      end
      6'h23: begin e_rf = 1; e_wa = ins[20:16]; e_wd = ref_mem[ea[11:2]]; e_lat = 5; end
      6'h2B: begin e_st = 1; e_sa = ea[11:2]; e_sd = b; ref_mem[ea[11:2]] = b; e_lat = 4; end
      6'h04: begin e_lat = 3; if (a == b) npc = npc + (sx << 2); end
      6'h08: begin e_rf = 1; e_wa = ins[20:16]; e_wd = a + sx; e_lat = 4; end
      6'h02: begin npc = {npc[31:28], ins[25:0], 2'b00}; e_lat = 3; end
      default: e_halt = 1;
    endcase
    if (e_rf && e_wa != 5'd0) ref_gpr[e_wa] = e_wd;
    if (!e_halt) ref_pc = npc;
  endtask

  // Clocks the DUT through one instruction, recording what it does on its ports.
  task automatic run_instr(input logic [31:0] exp_pc,
                           output bit g_rf, output logic [4:0] g_wa, output logic [31:0] g_wd,
                           output bit g_st, output logic [9:0] g_sa, output logic [31:0] g_sd,
                           output int cyc, output int stalls, output bit g_halt, output bit g_done);
    g_rf = 0; g_wa = 0; g_wd = 0; g_st = 0; g_sa = 0; g_sd = 0;
    cyc = 0; stalls = 0; g_halt = 0; g_done = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (stall_left > 0) begin
        mem_ready = 1'b0;
        stall_left--;
      end else if (rand_ready) mem_ready = 1'($urandom_range(0, 1));
      else mem_ready = 1'b1;
      #1;
      cyc++;
      if (state === 4'd0) begin
        chk("fetch.pc", pc, exp_pc);
        chk("fetch.addr", {22'd0, mem_addr}, {22'd0, exp_pc[11:2]});
        chk("fetch.req", {31'd0, mem_req}, 32'd1);
      end
      if (mem_req && !mem_ready) stalls++;
      if (rf_we) begin g_rf = 1; g_wa = rf_wa; g_wd = rf_wd; end
      if (mem_req && mem_we && mem_ready) begin
        g_st = 1; g_sa = mem_addr; g_sd = mem_wdata;
        mem[mem_addr] = mem_wdata;
      end
      if (halted) begin g_halt = 1; break; end
      if (instr_done) begin g_done = 1; break; end
    end
  endtask

  task automatic exec_check(input string tag, output int cyc);
    bit g_rf, g_st, g_halt, g_done, e_rf, e_st, e_halt;
    logic [4:0]  g_wa, e_wa;
    logic [31:0] g_wd, g_sd, e_wd, e_sd, exp_pc;
    logic [9:0]  g_sa, e_sa;
    int stalls, e_lat;
    exp_pc = ref_pc;
    run_instr(exp_pc, g_rf, g_wa, g_wd, g_st, g_sa, g_sd, cyc, stalls, g_halt, g_done);
    ref_step(e_rf, e_wa, e_wd, e_st, e_sa, e_sd, e_lat, e_halt);
    if (e_halt) begin
      chk({tag, ".halted"}, {31'd0, g_halt}, 32'd1);
    end else begin
      chk({tag, ".done"}, {31'd0, g_done}, 32'd1);
      chk({tag, ".rf_we"}, {31'd0, g_rf}, {31'd0, e_rf});
      if (e_rf) begin
        chk({tag, ".rf_wa"}, {27'd0, g_wa}, {27'd0, e_wa});
        chk({tag, ".rf_wd"}, g_wd, e_wd);
      end
      chk({tag, ".store"}, {31'd0, g_st}, {31'd0, e_st});
      if (e_st) begin
        chk({tag, ".st_addr"}, {22'd0, g_sa}, {22'd0, e_sa});
        chk({tag, ".st_data"}, g_sd, e_sd);
      end
      chk({tag, ".cycles"}, cyc, e_lat + stalls);
    end
    $display("%s pc=%h instr=%h cycles=%0d stalls=%0d rf=%0d:%0d:%h st=%0d", tag, exp_pc,
             ref_mem[exp_pc[11:2]], cyc, stalls, g_rf, g_wa, g_wd, g_st);
  endtask

  task automatic gen_program(input int n);
    logic [5:0] fns [5];
    logic [4:0] rs, rt, rd;
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    clear_mem();
    for (int i = 512; i < 768; i++) load(i, $urandom);
    for (int i = 0; i < n; i++) begin
      rs = 5'($urandom_range(0, 15));
      rt = 5'($urandom_range(0, 15));
      rd = 5'($urandom_range(0, 15));
      case ($urandom_range(0, 9))
        0, 1:    load(i, enc_i(6'h08, rs, rt, 16'($urandom)));
        2, 3, 4: load(i, enc_r(rs, rt, rd, fns[$urandom_range(0, 4)]));
        5:       load(i, enc_i(6'h23, 5'd0, rt, 16'(4 * (512 + $urandom_range(0, 255)))));
        6:       load(i, enc_i(6'h2B, 5'd0, rt, 16'(4 * (512 + $urandom_range(0, 255)))));
        7:       load(i, enc_i(6'h04, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'd1));
        8:       load(i, {6'h02, 26'(i + 2)});
        default: load(i, enc_i(6'h08, 5'd0, 5'($urandom_range(1, 3)), 16'($urandom_range(0, 3))));
      endcase
    end
  endtask

  task automatic run_random(input int n);
    int cyc, cnt;
    gen_program(n);
    do_reset();
    cnt = 0;
    while (ref_pc < 32'(4 * n) && cnt < 200) begin
      exec_check("rand", cyc);
      cnt++;
    end
  endtask

  initial begin
    int cyc;
    reset = 1'b0;
    mem_ready = 1'b0;
    clear_mem();
    load(0, enc_i(6'h08, 5'd0, 5'd8, 16'd5));
    load(1, enc_i(6'h08, 5'd0, 5'd9, 16'hFFFD));
    load(2, enc_r(5'd8, 5'd9, 5'd10, 6'h20));
    load(3, enc_i(6'h2B, 5'd0, 5'd10, 16'd8));
    load(4, enc_i(6'h23, 5'd0, 5'd11, 16'd8));
    load(5, enc_i(6'h08, 5'd0, 5'd12, 16'd7));
    load(6, enc_i(6'h04, 5'd8, 5'd8, 16'hFFFF));
    load(7, 32'hFC00_0000);
    do_reset();

    exec_check("addi8", cyc);
    chk("t1.cycles", cyc, 4);
    exec_check("addi9", cyc);
    exec_check("add10", cyc);
    exec_check("sw", cyc);
    exec_check("lw", cyc);
    chk("t2.lw_cycles", cyc, 5);

    stall_left = 3;
    exec_check("fetch_stall", cyc);
    chk("t3.cycles", cyc, 7);

    exec_check("beq_taken", cyc);
    load(6, enc_i(6'h04, 5'd8, 5'd9, 16'd4));
    exec_check("beq_not", cyc);
    chk("t4.pc_after", ref_pc, 32'd28);
    exec_check("illegal", cyc);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      mem_ready = 1'b1;
      #1;
      chk("halt.req", {31'd0, mem_req}, 32'd0);
      chk("halt.done", {31'd0, instr_done}, 32'd0);
    end
    chk("halt.state", {28'd0, state}, 32'd15);
    chk("halt.flag", {31'd0, halted}, 32'd1);
    do_reset();

    clear_mem();
    load(0, enc_i(6'h08, 5'd0, 5'd8, 16'd5));
    load(1, enc_i(6'h23, 5'd0, 5'd11, 16'd8));
    load(2, 32'h0000_1234);
    do_reset();
    exec_check("t6.addi", cyc);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (state === 4'd3) break;
      mem_ready = 1'b1;
    end
    chk("t6.in_memrd", {28'd0, state}, 32'd3);
    mem_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1'b1;
    #1;
    chk("t6.rf_we", {31'd0, rf_we}, 32'd0);
    chk("t6.req", {31'd0, mem_req}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    chk("t6.pc", pc, 32'd0);
    chk("t6.state", {28'd0, state}, 32'd0);
    model_reset();
    load(0, enc_r(5'd8, 5'd11, 5'd12, 6'h20));
    load(1, enc_r(5'd11, 5'd8, 5'd14, 6'h25));
    exec_check("t6.add0", cyc);
    exec_check("t6.or0", cyc);

    rand_ready = 1'b0;
    run_random(60);
    rand_ready = 1'b1;
    run_random(60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
